// File: rtl/register_file_mp.sv
// Multi-ported register file with per-register pending (scoreboard) bits.
// Two write ports (wr1 has priority), NUM_RD combinational read ports with write-first bypass.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              rst_hold;
  logic              wr0_v;
  logic              wr1_v;
  logic              claim_v;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // rst_hold masks the first clock edge after reset release, so an access
  // coincident with deassertion never lands.
  assign wr0_v   = wr0_en   & ~reset & ~rst_hold & addr_ok(wr0_addr);
  assign wr1_v   = wr1_en   & ~reset & ~rst_hold & addr_ok(wr1_addr);
  assign claim_v = claim_en & ~reset & ~rst_hold & addr_ok(claim_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_hold <= 1'b1;
      pending  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      rst_hold <= 1'b0;
      if (wr0_v) begin
        regs[wr0_addr]    <= wr0_data;
        pending[wr0_addr] <= 1'b0;
      end
      if (wr1_v) begin
        regs[wr1_addr]    <= wr1_data;
        pending[wr1_addr] <= 1'b0;
      end
      // A claim issued alongside a completing write marks a new producer.
      if (claim_v) begin
        pending[claim_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;

    assign ra = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs[ra];
      b = pending[ra];
      if (wr0_v && (wr0_addr == ra)) begin
        d = wr0_data;
        b = 1'b0;
      end
      if (wr1_v && (wr1_addr == ra)) begin
        d = wr1_data;
        b = 1'b0;
      end
      if (reset || !addr_ok(ra)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = d;
    assign rd_busy[g]                  = b;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NUM_RD, default 2, legal range 1..4, number of read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never written or claimed.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_W, packed read data, same packing order as rd_addr.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD, per-port flag: the addressed register has a pending producer.
REQ-010 The block SHALL have ports wr0_en (input, 1), wr0_addr (input, ADDR_W) and wr0_data (input, DATA_W), forming write port 0.
REQ-011 The block SHALL have ports wr1_en (input, 1), wr1_addr (input, ADDR_W) and wr1_data (input, DATA_W), forming write port 1, higher priority than port 0.
REQ-012 The block SHALL have ports claim_en (input, 1) and claim_addr (input, ADDR_W), which mark a register pending; driven at instruction issue.

Function
REQ-013 The block SHALL hold 2**ADDR_W registers of DATA_W bits and one pending bit per register.
REQ-014 Reads SHALL be combinational: rd_data[i] = regs[rd_addr[i]] with zero cycles of latency.
REQ-015 Write-first bypass: when wrX_en is high and wrX_addr == rd_addr[i] in the same cycle, rd_data[i] SHALL equal wrX_data.
REQ-016 When both write ports are enabled to the same address, wr1_data SHALL be stored at the clock edge and bypassed to reads; wr0 is discarded.
REQ-017 When wr0 and wr1 target different addresses, both SHALL be stored at the same edge.
REQ-018 With ZERO_REG=1, rd_data[i] SHALL be 0 and rd_busy[i] SHALL be 0 whenever rd_addr[i]==0, regardless of writes, claims or bypass.
REQ-019 With ZERO_REG=1, writes and claims to address 0 SHALL have no effect.
REQ-020 claim_en SHALL set pending[claim_addr] at the clock edge.
REQ-021 An enabled write SHALL clear pending[wrX_addr] at the clock edge.
REQ-022 When a claim and a write target the same address in the same cycle, the claim SHALL win: the data is stored and the pending bit stays set (new producer in flight).
REQ-023 rd_busy[i] SHALL be pending[rd_addr[i]], forced to 0 when an enabled write to rd_addr[i] occurs in the same cycle (the write result is bypassed).
REQ-024 A claim SHALL NOT affect rd_busy in its own cycle; the pending bit is visible from the next cycle.
REQ-025 Writes with wrX_en low SHALL leave all state unchanged; addresses and data are don't-care.
REQ-026 There SHALL be no limit on the number of simultaneously pending registers; a re-claim of an already-pending register is idempotent.

Reset
REQ-027 While reset is high, all registers and all pending bits SHALL be 0, asynchronously, without waiting for a clock edge.
REQ-028 During reset, rd_data SHALL read 0 and rd_busy SHALL be 0 on every port; writes and claims are ignored.
REQ-029 A write or claim coincident with the reset-deassertion edge SHALL be ignored; the first effective edge is the one after deassertion.
REQ-030 Reset asserted mid-operation SHALL discard all pending bits and data immediately.

Verification
REQ-031 Basic write/read: wr0 writes 0x0000_00AA to r1, next cycle rd_addr0=1 -> rd_data0=0x0000_00AA, rd_busy0=0.
REQ-032 Bypass and priority: wr0 writes r3=0x11 and wr1 writes r3=0x22 in the same cycle with rd_addr1=3 -> rd_data1=0x22 in that cycle; after the edge r3 reads 0x22.
REQ-033 Zero register: write r0=0xFFFF_FFFF and claim r0 -> rd_data=0 and rd_busy=0 on every port, in that cycle and every later cycle.
REQ-034 Scoreboard: claim r5 -> rd_busy=1 for r5 from the next cycle; write r5=0x55 -> rd_busy=0 and rd_data=0x55 in the write cycle; claim and write to r5 in the same cycle -> r5=0x55 is stored and r5 stays busy.
REQ-035 Async reset: fill r1..r4 and claim r2, then assert reset between clock edges -> all rd_data=0 and all rd_busy=0 immediately; a write on the deassertion edge is not stored.
REQ-036 Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=0 -> r0 is writable, four independent reads of r0..r3 are correct, and bypass works on all four ports.
